ex_mem_stage_reg: RTL

Parametrised elastic EX/MEM pipeline stage register for the 5-stage MIPS core. It carries EX-stage control bits, destination register, ALU result and store data into the MEM stage, using a valid/ready handshake on both sides. A one-entry skid buffer keeps ex_ready registered, so no combinational path runs from mem_ready back to ex_ready. It also supports synchronous flush (bubble insertion), forwarding outputs taken from the youngest in-flight entry, and a saturating stall counter for performance debug.

---
 rtl/mips_pipe_pkg.sv | 29 ++
 rtl/pipe_skid_buf.sv | 91 +++++++++
 rtl/ex_mem_stage_reg.sv | 106 ++++++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared types for the MIPS pipeline stage registers.
// The payload struct uses the core's default widths; modules built with other widths declare a matching local struct.
package mips_pipe_pkg;

  // Encoded so that bit 0 = head valid and bit 1 = skid valid
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } stage_state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_RD_W   = 5;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  mem_read;
    logic                  mem_write;
    logic [DEF_RD_W-1:0]   rd;
    logic [DEF_DATA_W-1:0] alu_result;
    logic [DEF_DATA_W-1:0] rt_data;
  } ex_mem_payload_t;

  function automatic int payloadWidth(input int dataW, input int rdW);
    return 4 + rdW + 2 * dataW;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready storage (head + skid) with a registered input ready.
// Entries leave strictly in order; flush empties the buffer in one cycle.
module pipe_skid_buf
  import mips_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_skidValid,
  output logic [WIDTH-1:0] o_skidData
);

  stage_state_t     r_state;
  stage_state_t     w_nextState;
  logic             r_ready;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_skid;
  logic             w_accept;
  logic             w_consume;
  logic             w_loadH;
  logic             w_loadS;
  logic             w_shift;

  assign w_accept  = i_valid & r_ready;
  assign w_consume = r_state[0] & i_ready;

  // Ready is computed from the next state so it never depends combinationally on i_ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_nextState;
      r_ready <= (w_nextState != TWO);
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (i_flush) begin
      w_nextState = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_accept) w_nextState = ONE;
        ONE: begin
          if (w_accept && !w_consume)      w_nextState = TWO;
          else if (!w_accept && w_consume) w_nextState = EMPTY;
        end
        TWO:     if (w_consume) w_nextState = ONE;
        default: w_nextState = EMPTY;
      endcase
    end
  end

  always_comb begin
    w_loadH = 1'b0;
    w_loadS = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      EMPTY: w_loadH = w_accept;
      ONE: begin
        w_loadH = w_accept & w_consume;
        w_loadS = w_accept & ~w_consume;
      end
      TWO:     w_shift = w_consume;
      default: ;
    endcase
  end

  // Payloads carry no reset; validity lives entirely in r_state
  always_ff @(posedge clk) begin
    if (w_shift)      r_head <= r_skid;
    else if (w_loadH) r_head <= i_data;
    if (w_loadS)      r_skid <= i_data;
  end

  assign o_ready     = r_ready;
  assign o_valid     = r_state[0];
  assign o_data      = r_head;
  assign o_skidValid = r_state[1];
  assign o_skidData  = r_skid;

endmodule

// File: rtl/ex_mem_stage_reg.sv
// Elastic EX/MEM stage register: skid-buffered handshake, valid-gated MEM controls,
// forwarding from the youngest in-flight entry and a saturating stall counter.
module ex_mem_stage_reg
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int RD_W        = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   ex_valid,
  output logic                   ex_ready,
  input  logic                   ex_reg_write,
  input  logic                   ex_mem_to_reg,
  input  logic                   ex_mem_read,
  input  logic                   ex_mem_write,
  input  logic [RD_W-1:0]        ex_rd,
  input  logic [DATA_W-1:0]      ex_alu_result,
  input  logic [DATA_W-1:0]      ex_rt_data,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic                   mem_reg_write,
  output logic                   mem_mem_to_reg,
  output logic                   mem_mem_read,
  output logic                   mem_mem_write,
  output logic [RD_W-1:0]        mem_rd,
  output logic [DATA_W-1:0]      mem_alu_result,
  output logic [DATA_W-1:0]      mem_rt_data,
  output logic                   fwd_reg_write,
  output logic [RD_W-1:0]        fwd_rd,
  output logic [DATA_W-1:0]      fwd_data,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int PAYLOAD_W = payloadWidth(DATA_W, RD_W);

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_read;
    logic              mem_write;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] rt_data;
  } payload_t;

  payload_t                   w_inPayload;
  payload_t                   w_head;
  payload_t                   w_skid;
  payload_t                   w_youngest;
  logic                       w_headValid;
  logic                       w_skidValid;
  logic [STALL_CNT_W-1:0]     r_stallCount;

  assign w_inPayload = '{reg_write:  ex_reg_write,
                         mem_to_reg: ex_mem_to_reg,
                         mem_read:   ex_mem_read,
                         mem_write:  ex_mem_write,
                         rd:         ex_rd,
                         alu_result: ex_alu_result,
                         rt_data:    ex_rt_data};

  pipe_skid_buf #(
    .WIDTH(PAYLOAD_W)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (flush),
    .i_valid    (ex_valid),
    .i_data     (w_inPayload),
    .o_ready    (ex_ready),
    .o_valid    (w_headValid),
    .i_ready    (mem_ready),
    .o_data     (w_head),
    .o_skidValid(w_skidValid),
    .o_skidData (w_skid)
  );

  assign mem_valid      = w_headValid;
  assign mem_reg_write  = w_headValid & w_head.reg_write;
  assign mem_mem_to_reg = w_headValid & w_head.mem_to_reg;
  assign mem_mem_read   = w_headValid & w_head.mem_read;
  assign mem_mem_write  = w_headValid & w_head.mem_write;
  assign mem_rd         = w_head.rd;
  assign mem_alu_result = w_head.alu_result;
  assign mem_rt_data    = w_head.rt_data;

  // The skid entry is always younger than the head; writes to $zero are never forwarded
  assign w_youngest    = w_skidValid ? w_skid : w_head;
  assign fwd_reg_write = w_headValid & w_youngest.reg_write & (w_youngest.rd != '0);
  assign fwd_rd        = w_headValid ? w_youngest.rd : '0;
  assign fwd_data      = w_headValid ? w_youngest.alu_result : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stallCount <= '0;
    end else if (w_headValid && !mem_ready && (r_stallCount != '1)) begin
      r_stallCount <= r_stallCount + 1'b1;
    end
  end

  assign stall_count = r_stallCount;

endmodule
